// File: rtl/jtframe_mbox_pkg.sv
// Shared constants for the MCU mailbox: default widths,
// FIFO depth helper and reset values of the status outputs.
package jtframe_mbox_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2;
  localparam int DEPTH  = 2**DEF_AW;

  localparam logic RST_IRQ  = 1'b0;
  localparam logic RST_STN  = 1'b1;
  localparam logic RST_FULL = 1'b0;
  localparam logic RST_OVF  = 1'b0;
  localparam logic RST_STRB = 1'b1;

  function automatic int depth_of(input int aw);
    return 2**aw;
  endfunction

endpackage

// File: rtl/jtframe_mbox_fifo.sv
// One mailbox direction: FIFO with registered head, or a single
// legacy latch when JTFRAME_MBOX_FIFO_EN is not defined.
module jtframe_mbox_fifo
  import jtframe_mbox_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

`ifdef JTFRAME_MBOX_FIFO_EN

  localparam int DEPTH_L = depth_of(AW);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH_L);

  logic [DW-1:0] mem [DEPTH_L];
  logic [AW-1:0] wr, rd, rd_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic          push_ok, pop_ok;
  logic [DW-1:0] dout_nxt;

  // Accept/reject strobes and work out the head after this edge
  always_comb begin
    empty    = cnt == '0;
    full     = cnt == FULL_CNT;
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop);
    rd_nxt   = rd + AW'(pop_ok);
    cnt_nxt  = cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout_nxt = '0;
    if (cnt_nxt != '0)
      dout_nxt = (push_ok && rd_nxt == wr) ? din : mem[rd_nxt];
  end

  // Pointers, count, registered head and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr   <= '0;
      rd   <= '0;
      cnt  <= '0;
      dout <= '0;
      ovf  <= RST_OVF;
    end else if (clr) begin
      wr   <= '0;
      rd   <= '0;
      cnt  <= '0;
      dout <= '0;
      ovf  <= RST_OVF;
    end else begin
      wr   <= wr + AW'(push_ok);
      rd   <= rd_nxt;
      cnt  <= cnt_nxt;
      dout <= dout_nxt;
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr] <= din;
  end

`else

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0] cnt;

  // Single-entry occupancy flags
  always_comb begin
    empty = cnt == '0;
    full  = cnt == ONE;
  end

  // Legacy latch: push always overwrites, pop clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= '0;
      ovf  <= RST_OVF;
    end else if (clr) begin
      cnt  <= '0;
      dout <= '0;
      ovf  <= RST_OVF;
    end else if (push) begin
      cnt  <= ONE;
      dout <= din;
      if (full & ~pop) ovf <= 1'b1;
    end else if (pop) begin
      cnt  <= '0;
      dout <= '0;
    end
  end

`endif

endmodule

// File: rtl/jtframe_mcu_mbox.sv
// Main CPU <-> MCU mailbox. FIFO build: define JTFRAME_MBOX_FIFO_EN,
// otherwise each direction is a single legacy latch.
module jtframe_mcu_mbox
  import jtframe_mbox_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          main_wr,
  input  logic          main_rd,
  input  logic          main_clr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  input  logic          mcu_wrn,
  input  logic          mcu_rdn,
  input  logic [DW-1:0] mcu_din,
  output logic [DW-1:0] mcu_dout,
  output logic          mcu_irq,
  output logic          main_stn,
  output logic          m2s_full,
  output logic          s2m_full,
  output logic          ovf
);

  logic wrn_q, wrn_p, wr_arm;
  logic rdn_q, rdn_p, rd_arm;
  logic s2m_push, m2s_pop;
  logic m2s_empty, s2m_empty;
  logic m2s_ovf, s2m_ovf;

  // MCU strobe sampling; arm bits ignore a pin held low out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn_q  <= RST_STRB;
      wrn_p  <= RST_STRB;
      rdn_q  <= RST_STRB;
      rdn_p  <= RST_STRB;
      wr_arm <= 1'b0;
      rd_arm <= 1'b0;
    end else begin
      wrn_q  <= mcu_wrn;
      wrn_p  <= wrn_q;
      rdn_q  <= mcu_rdn;
      rdn_p  <= rdn_q;
      wr_arm <= wr_arm | mcu_wrn;
      rd_arm <= rd_arm | mcu_rdn;
    end
  end

  assign s2m_push = wr_arm & wrn_p & ~wrn_q;
  assign m2s_pop  = rd_arm & rdn_p & ~rdn_q;

  jtframe_mbox_fifo #(.DW(DW), .AW(AW)) u_m2s (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .push  (main_wr),
    .pop   (m2s_pop),
    .din   (main_din),
    .dout  (mcu_dout),
    .empty (m2s_empty),
    .full  (m2s_full),
    .ovf   (m2s_ovf)
  );

  jtframe_mbox_fifo #(.DW(DW), .AW(AW)) u_s2m (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .push  (s2m_push),
    .pop   (main_rd),
    .din   (mcu_din),
    .dout  (main_dout),
    .empty (s2m_empty),
    .full  (s2m_full),
    .ovf   (s2m_ovf)
  );

  assign mcu_irq  = ~m2s_empty;
  assign main_stn = s2m_empty;
  assign ovf      = m2s_ovf | s2m_ovf;

endmodule
